// File: rtl/mem_stream_reader.sv
// Periodic memory-to-output streamer.
// Reads base..limit from an external memory with an active-low strobe and
// presents one word on `out` every PERIOD clocks, with stop/done status.
module mem_stream_reader #(
  parameter int DW          = 8,
  parameter int AW          = 24,
  parameter int WAIT_CYCLES = 0,
  parameter int PERIOD      = 100
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ok,
  input  logic [DW-1:0] d_in,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] limit_addr,
  input  logic          wrap,
  output logic          stop,
  output logic          mr_,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] out,
  output logic          out_valid,
  output logic          done
);

  // A full read (1+WAIT_CYCLES strobe cycles plus capture) must fit inside
  // one period, otherwise emits could not keep exact spacing.
  if (PERIOD < WAIT_CYCLES + 3) begin : g_bad_period
    $error("mem_stream_reader: PERIOD must be >= WAIT_CYCLES+3");
  end

  localparam int CW = $clog2(PERIOD);
  localparam int WW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CMAX = CW'(PERIOD - 1);
  localparam logic [WW-1:0] WMAX = WW'(WAIT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_CAPTURE, S_HOLD, S_DONE
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [WW-1:0]   wcnt, wcnt_n;
  logic [DW-1:0]   data_buf, data_buf_n;
  logic [AW-1:0]   base_q, base_n;
  logic [AW-1:0]   lim_q, lim_n;
  logic            wrap_q, wrap_n;
  logic            last_q, last_n;
  logic            stop_n, mr_n, ov_n, done_n;
  logic [AW-1:0]   addr_n;
  logic [DW-1:0]   out_n;

  // Register every state bit and output; reset wins over any in-flight read.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      wcnt      <= '0;
      data_buf  <= '0;
      base_q    <= '0;
      lim_q     <= '0;
      wrap_q    <= 1'b0;
      last_q    <= 1'b0;
      stop      <= 1'b1;
      mr_       <= 1'b1;
      addr      <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      wcnt      <= wcnt_n;
      data_buf  <= data_buf_n;
      base_q    <= base_n;
      lim_q     <= lim_n;
      wrap_q    <= wrap_n;
      last_q    <= last_n;
      stop      <= stop_n;
      mr_       <= mr_n;
      addr      <= addr_n;
      out       <= out_n;
      out_valid <= ov_n;
      done      <= done_n;
    end
  end

  // Next-state and next-output logic; out_valid is a single-cycle pulse.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    wcnt_n     = wcnt;
    data_buf_n = data_buf;
    base_n     = base_q;
    lim_n      = lim_q;
    wrap_n     = wrap_q;
    last_n     = last_q;
    stop_n     = stop;
    mr_n       = mr_;
    addr_n     = addr;
    out_n      = out;
    ov_n       = 1'b0;
    done_n     = done;

    // The period counter free-runs through a transfer; emits reload it.
    if (state == S_READ || state == S_CAPTURE || state == S_HOLD)
      cnt_n = cnt + CW'(1);

    case (state)
      S_IDLE: begin
        stop_n = 1'b1;
        if (ok) begin
          base_n  = base_addr;
          lim_n   = limit_addr;
          wrap_n  = wrap;
          addr_n  = base_addr;
          cnt_n   = '0;
          wcnt_n  = '0;
          last_n  = 1'b0;
          mr_n    = 1'b0;
          state_n = S_READ;
        end
      end
      S_READ: begin
        // Hold the strobe low for 1+WAIT_CYCLES cycles; ok is ignored here.
        if (wcnt == WMAX) begin
          mr_n    = 1'b1;
          state_n = S_CAPTURE;
        end else begin
          wcnt_n = wcnt + WW'(1);
        end
      end
      S_CAPTURE: begin
        data_buf_n = d_in;
        stop_n     = 1'b0;
        // Equality compare only, so limit < base wraps through 2^AW.
        if (addr != lim_q)  addr_n = addr + AW'(1);
        else if (wrap_q)    addr_n = base_q;
        else                last_n = 1'b1;
        state_n = S_HOLD;
      end
      S_HOLD: begin
        if (!ok) begin
          stop_n  = 1'b1;
          state_n = S_IDLE;
        end else if (cnt == CMAX) begin
          out_n = data_buf;
          ov_n  = 1'b1;
          cnt_n = '0;
          if (last_q) begin
            done_n  = 1'b1;
            stop_n  = 1'b1;
            state_n = S_DONE;
          end else begin
            mr_n    = 1'b0;
            wcnt_n  = '0;
            state_n = S_READ;
          end
        end
      end
      S_DONE: begin
        done_n = 1'b1;
        stop_n = 1'b1;
        mr_n   = 1'b1;
        if (!ok) begin
          done_n  = 1'b0;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule
